// File: rtl/l0_skew_fifo_if.sv
// Bundle of the data, handshake and status signals of the skewed row FIFO.
// The master side feeds write/read requests; the slave side is the FIFO itself.
interface l0_skew_fifo_if #(
    parameter int ROW   = 8,
    parameter int BW    = 4,
    parameter int DEPTH = 64
);
    localparam int AW = $clog2(DEPTH);

    logic [ROW*BW-1:0] in;
    logic              wr;
    logic              rd;
    logic              mode;
    logic [ROW*BW-1:0] out;
    logic [ROW-1:0]    o_valid;
    logic              o_full;
    logic              o_ready;
    logic [AW:0]       o_count;
    logic              o_ovf;
    logic              o_udf;

    modport master (
        output in, wr, rd, mode,
        input  out, o_valid, o_full, o_ready, o_count, o_ovf, o_udf
    );

    modport slave (
        input  in, wr, rd, mode,
        output out, o_valid, o_full, o_ready, o_count, o_ovf, o_udf
    );
endinterface

// File: rtl/l0_skew_fifo.sv
// ROW lock-step FIFOs written together and read either in parallel or as a
// diagonal wave (row 0 first) driven by a shifting read-enable register.
module l0_skew_fifo #(
    parameter int ROW   = 8,
    parameter int BW    = 4,
    parameter int DEPTH = 64
) (
    input logic          clk,
    input logic          reset,
    l0_skew_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [ROW-1:0] rd_en;
    logic [ROW-1:0] full;
    logic [ROW-1:0] empty;
    logic [ROW-1:0] pop;
    logic [CW-1:0]  cnt_last;
    logic           wr_ok;
    logic           ovf;
    logic           udf;

    // Full on any row blocks the whole vector, so rows never drift apart on writes.
    assign wr_ok = bus.wr && !(|full);

    // Stage p0: read-enable register (broadcast in mode 0, diagonal shift in mode 1)
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_en <= '0;
        end else if (!bus.mode) begin
            rd_en <= {ROW{bus.rd}};
        end else begin
            rd_en <= {rd_en[ROW-2:0], bus.rd};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (bus.wr && (|full)) begin
                ovf <= 1'b1;
            end
            if (|(rd_en & empty)) begin
                udf <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < ROW; i++) begin : g_row
        logic [BW-1:0] mem [DEPTH];
        logic [AW-1:0] wptr;
        logic [AW-1:0] rptr;
        logic [CW-1:0] cnt;
        logic [BW-1:0] dout_p1;
        logic          vld_p1;

        assign full[i]  = (cnt == FULL_CNT);
        assign empty[i] = (cnt == '0);
        assign pop[i]   = rd_en[i] && !empty[i];

        always_ff @(posedge clk) begin
            if (wr_ok) begin
                mem[wptr] <= bus.in[i*BW +: BW];
            end
        end

        // Stage p1: pop into the output register, pointer and occupancy update
        always_ff @(posedge clk) begin
            if (reset) begin
                wptr    <= '0;
                rptr    <= '0;
                cnt     <= '0;
                dout_p1 <= '0;
                vld_p1  <= 1'b0;
            end else begin
                vld_p1 <= pop[i];
                if (wr_ok) begin
                    wptr <= wptr + AW'(1);
                end
                if (pop[i]) begin
                    dout_p1 <= mem[rptr];
                    rptr    <= rptr + AW'(1);
                end
                if (wr_ok && !pop[i]) begin
                    cnt <= cnt + CW'(1);
                end else if (!wr_ok && pop[i]) begin
                    cnt <= cnt - CW'(1);
                end
            end
        end

        assign bus.out[i*BW +: BW] = dout_p1;
        assign bus.o_valid[i]      = vld_p1;

        if (i == ROW - 1) begin : g_last
            assign cnt_last = cnt;
        end
    end

    assign bus.o_full  = |full;
    assign bus.o_ready = &empty;
    assign bus.o_count = cnt_last;
    assign bus.o_ovf   = ovf;
    assign bus.o_udf   = udf;
endmodule

// File: tb/tb_l0_skew_fifo.sv
// Bench for l0_skew_fifo: directed scenarios plus a random phase, each cycle
// checked against a queue-per-row reference model.
module tb_l0_skew_fifo;
    localparam int ROW   = 8;
    localparam int BW    = 4;
    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);
    localparam int MAXC  = 4096;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    l0_skew_fifo_if #(.ROW(ROW), .BW(BW), .DEPTH(DEPTH)) bus ();

    l0_skew_fifo #(.ROW(ROW), .BW(BW), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Reference model: per-row queues of entries plus input history.
    logic [BW-1:0]  q [ROW][$];
    logic [BW-1:0]  m_out [ROW];
    logic [ROW-1:0] m_valid;
    logic           m_ovf;
    logic           m_udf;
    bit             rd_h   [MAXC];
    bit             mode_h [MAXC];
    bit             rst_h  [MAXC];
    int             cyc = 0;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Is row 'row' read-enabled during cycle c? Mode 0 broadcasts the previous
    // cycle's rd; mode 1 inherits the neighbour's enable one cycle earlier.
    function automatic bit en_at(input int row, input int c);
        int r = row;
        int p = c;
        while (1) begin
            if (p == 0) return 1'b0;
            p--;
            if (rst_h[p]) return 1'b0;
            if (!mode_h[p] || r == 0) return rd_h[p];
            r--;
        end
        return 1'b0;
    endfunction

    task automatic tick();
        bit               en [ROW];
        bit               full_pre;
        bit               any_full;
        bit               all_empty;
        logic [ROW*BW-1:0] outv;
        @(posedge clk);
        if (cyc < MAXC) begin
            rst_h[cyc]  = reset;
            rd_h[cyc]   = bus.rd;
            mode_h[cyc] = bus.mode;
        end
        for (int i = 0; i < ROW; i++) en[i] = en_at(i, cyc);
        if (reset) begin
            for (int i = 0; i < ROW; i++) begin
                q[i].delete();
                m_out[i] = '0;
            end
            m_valid = '0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
        end else begin
            full_pre = 1'b0;
            for (int i = 0; i < ROW; i++) if (q[i].size() == DEPTH) full_pre = 1'b1;
            if (bus.wr && full_pre) m_ovf = 1'b1;
            for (int i = 0; i < ROW; i++) begin
                m_valid[i] = 1'b0;
                if (en[i]) begin
                    if (q[i].size() == 0) m_udf = 1'b1;
                    else begin
                        m_out[i]   = q[i].pop_front();
                        m_valid[i] = 1'b1;
                    end
                end
            end
            if (bus.wr && !full_pre)
                for (int i = 0; i < ROW; i++) q[i].push_back(bus.in[i*BW +: BW]);
        end
        cyc++;
        #1;
        any_full  = 1'b0;
        all_empty = 1'b1;
        for (int i = 0; i < ROW; i++) begin
            outv[i*BW +: BW] = m_out[i];
            if (q[i].size() == DEPTH) any_full = 1'b1;
            if (q[i].size() != 0) all_empty = 1'b0;
        end
        chk("out",     64'(bus.out),     64'(outv));
        chk("o_valid", 64'(bus.o_valid), 64'(m_valid));
        chk("o_full",  64'(bus.o_full),  64'(any_full));
        chk("o_ready", 64'(bus.o_ready), 64'(all_empty));
        chk("o_count", 64'(bus.o_count), 64'(q[ROW-1].size()));
        chk("o_ovf",   64'(bus.o_ovf),   64'(m_ovf));
        chk("o_udf",   64'(bus.o_udf),   64'(m_udf));
    endtask

    task automatic drive(input bit rs, input bit w, input bit r, input bit m);
        reset    = rs;
        bus.wr   = w;
        bus.rd   = r;
        bus.mode = m;
        bus.in   = (ROW*BW)'($urandom);
    endtask

    function automatic logic [ROW*BW-1:0] ramp(input int k);
        logic [ROW*BW-1:0] v;
        for (int i = 0; i < ROW; i++) v[i*BW +: BW] = BW'(i + k);
        return v;
    endfunction

    task automatic do_reset();
        drive(1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0);
    endtask

    initial begin
        int n;
        // Power-on reset
        drive(1, 0, 0, 0);
        tick();
        tick();
        chk("rst_ready", 64'(bus.o_ready), 64'd1);
        chk("rst_full",  64'(bus.o_full),  64'd0);
        chk("rst_count", 64'(bus.o_count), 64'd0);
        chk("rst_valid", 64'(bus.o_valid), 64'd0);
        drive(0, 0, 0, 0);

        // Parallel read of three ramp vectors
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 0);
            bus.in = ramp(k);
            tick();
        end
        drive(0, 0, 1, 0);
        tick();
        tick();
        chk("par_valid0", 64'(bus.o_valid), 64'hFF);
        chk("par_data0",  64'(bus.out),     64'(ramp(0)));
        tick();
        chk("par_valid1", 64'(bus.o_valid), 64'hFF);
        chk("par_data1",  64'(bus.out),     64'(ramp(1)));
        drive(0, 0, 0, 0);
        tick();
        chk("par_valid2", 64'(bus.o_valid), 64'hFF);
        chk("par_data2",  64'(bus.out),     64'(ramp(2)));
        tick();
        chk("par_ready", 64'(bus.o_ready), 64'd1);
        chk("par_idle",  64'(bus.o_valid), 64'd0);

        // Skewed single-entry read
        drive(0, 1, 0, 1);
        tick();
        drive(0, 0, 1, 1);
        tick();
        drive(0, 0, 0, 1);
        for (int k = 0; k < ROW; k++) begin
            tick();
            chk("skew_valid", 64'(bus.o_valid), 64'(1) << k);
        end
        tick();
        chk("skew_udf", 64'(bus.o_udf), 64'd0);

        // Simultaneous write and pop at count 5
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 0, 0);
            tick();
        end
        drive(0, 0, 1, 0);
        tick();
        drive(0, 1, 0, 0);
        tick();
        chk("wrrd_count", 64'(bus.o_count), 64'd5);
        chk("wrrd_valid", 64'(bus.o_valid), 64'hFF);

        // Fill, overflow, pop-while-full, wrap and drain
        do_reset();
        tick();
        for (int k = 0; k < DEPTH; k++) begin
            drive(0, 1, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0);
        chk("fill_full",  64'(bus.o_full),  64'd1);
        chk("fill_count", 64'(bus.o_count), 64'(DEPTH));
        chk("fill_ovf0",  64'(bus.o_ovf),   64'd0);
        drive(0, 1, 0, 0);
        tick();
        chk("ovf_set",   64'(bus.o_ovf),   64'd1);
        chk("ovf_count", 64'(bus.o_count), 64'(DEPTH));
        drive(0, 0, 1, 0);
        tick();
        for (int k = 0; k < 10; k++) begin
            drive(0, 1, 1, 0);
            tick();
        end
        drive(0, 0, 0, 0);
        tick();
        chk("wrap_count", 64'(bus.o_count), 64'(DEPTH - 2));
        n = q[ROW-1].size();
        for (int k = 0; k < n; k++) begin
            drive(0, 0, 1, 0);
            tick();
        end
        drive(0, 0, 0, 0);
        tick();
        tick();
        chk("drain_ready", 64'(bus.o_ready), 64'd1);
        chk("drain_udf",   64'(bus.o_udf),   64'd0);

        // Read of an empty FIFO
        do_reset();
        drive(0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0);
        tick();
        chk("udf_valid", 64'(bus.o_valid), 64'd0);
        chk("udf_set",   64'(bus.o_udf),   64'd1);
        chk("udf_count", 64'(bus.o_count), 64'd0);

        // Random traffic
        do_reset();
        for (int k = 0; k < 600; k++) begin
            drive(($urandom % 97) == 0, ($urandom % 3) != 0, ($urandom % 3) == 0,
                  ($urandom % 8) < 4);
            tick();
        end

        // Reset with skewed reads in flight
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(0, 1, 0, 1);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 1);
            tick();
        end
        drive(1, 1, 1, 1);
        tick();
        chk("rstf_ready", 64'(bus.o_ready), 64'd1);
        chk("rstf_valid", 64'(bus.o_valid), 64'd0);
        chk("rstf_count", 64'(bus.o_count), 64'd0);
        chk("rstf_out",   64'(bus.out),     64'd0);
        drive(0, 0, 0, 1);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("rstf_nopop", 64'(bus.o_valid), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
